// File: rtl/fir_stream_param_if.sv
// Streaming interface for fir_stream_param.
//   i_valid/i_data           : input sample stream (one sample per valid cycle)
//   i_coeff_we/_addr/_data   : coefficient bank write port
//   o_valid/o_data/o_sat     : filtered output stream with saturation flag
// master = sample/coefficient source, slave = the filter.
interface fir_stream_param_if #(
  parameter int N_TAPS    = 15,
  parameter int WW_INPUT  = 8,
  parameter int WW_COEFF  = 8,
  parameter int WW_OUTPUT = 8
);
  localparam int AW = $clog2(N_TAPS);

  logic                        i_valid;
  logic signed [WW_INPUT-1:0]  i_data;
  logic                        i_coeff_we;
  logic        [AW-1:0]        i_coeff_addr;
  logic signed [WW_COEFF-1:0]  i_coeff_data;
  logic                        o_valid;
  logic signed [WW_OUTPUT-1:0] o_data;
  logic                        o_sat;

  modport master (
    output i_valid, i_data, i_coeff_we, i_coeff_addr, i_coeff_data,
    input  o_valid, o_data, o_sat
  );

  modport slave (
    input  i_valid, i_data, i_coeff_we, i_coeff_addr, i_coeff_data,
    output o_valid, o_data, o_sat
  );
endinterface

// File: rtl/fir_stream_param.sv
// Parametrised direct-form FIR with valid-tagged streaming.
//   clk   : rising-edge clock
//   i_rst : asynchronous active-high reset (clears history, coefficients, pipeline)
//   strm  : fir_stream_param_if.slave (sample input, coefficient writes, output)
// Pipeline: product register, ceil(log2(N_TAPS)) registered adder levels,
// then a registered shift/saturate stage. A valid tag travels with the data.
module fir_stream_param #(
  parameter int N_TAPS    = 15,
  parameter int WW_INPUT  = 8,
  parameter int WW_COEFF  = 8,
  parameter int WW_OUTPUT = 8,
  parameter int SHIFT     = 7
) (
  input logic              clk,
  input logic              i_rst,
  fir_stream_param_if.slave strm
);
  localparam int unsigned NT  = N_TAPS;
  localparam int unsigned LVL = $clog2(N_TAPS);
  localparam int unsigned WP  = WW_INPUT + WW_COEFF;
  localparam int unsigned WA  = WP + LVL;

  localparam logic signed [WA-1:0] OMAX = {{(WA-WW_OUTPUT+1){1'b0}}, {(WW_OUTPUT-1){1'b1}}};
  localparam logic signed [WA-1:0] OMIN = ~OMAX;

  // Operand count at tree level l (level 0 = products).
  function automatic int unsigned nodes(input int unsigned l);
    return (NT + (32'd1 << l) - 32'd1) >> l;
  endfunction

  logic signed [WW_COEFF-1:0]  coeff_q [N_TAPS];
  logic signed [WW_INPUT-1:0]  dly_q   [1:N_TAPS-1];
  logic signed [WW_INPUT-1:0]  x       [N_TAPS];
  logic signed [WA-1:0]        prod_d  [N_TAPS];
  logic signed [WP-1:0]        mul;
  // Every level is held at the final width WA; operands are sign-extended, so
  // the arithmetic equals a tree that grows one bit per level. Column N_TAPS
  // is a constant zero spare so the right-operand index stays in range.
  logic signed [WA-1:0]        tree_q  [LVL+1][N_TAPS+1];
  logic        [LVL:0]         vld_q;

  logic signed [WA-1:0]        shifted;
  logic signed [WW_OUTPUT-1:0] o_data_d, o_data_q;
  logic                        o_sat_d, o_sat_q, o_valid_q;

  always_comb begin
    mul  = '0;
    x[0] = strm.i_data;
    for (int unsigned k = 1; k < NT; k++) x[k] = dly_q[k];
    for (int unsigned k = 0; k < NT; k++) begin
      mul       = WP'(coeff_q[k]) * WP'(x[k]);
      prod_d[k] = WA'(mul);
    end
  end

  // Coefficient bank; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NT; k++) coeff_q[k] <= '0;
    end else if (strm.i_coeff_we && (32'(strm.i_coeff_addr) < NT)) begin
      coeff_q[strm.i_coeff_addr] <= strm.i_coeff_data;
    end
  end

  // Delay line advances only on valid samples.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 1; k < NT; k++) dly_q[k] <= '0;
    end else if (strm.i_valid) begin
      dly_q[1] <= strm.i_data;
      for (int unsigned k = 2; k < NT; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  // Products load on valid samples; tree levels and tags advance every cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned l = 0; l <= LVL; l++)
        for (int unsigned j = 0; j <= NT; j++) tree_q[l][j] <= '0;
      vld_q <= '0;
    end else begin
      if (strm.i_valid)
        for (int unsigned k = 0; k < NT; k++) tree_q[0][k] <= prod_d[k];
      for (int unsigned l = 1; l <= LVL; l++) begin
        for (int unsigned j = 0; j < nodes(l); j++) begin
          if (2*j + 1 < nodes(l-1))
            tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
          else
            tree_q[l][j] <= tree_q[l-1][2*j];
        end
      end
      vld_q <= {vld_q[LVL-1:0], strm.i_valid};
    end
  end

  always_comb begin
    shifted  = tree_q[LVL][0] >>> SHIFT;
    o_sat_d  = 1'b0;
    o_data_d = shifted[WW_OUTPUT-1:0];
    if (shifted > OMAX) begin
      o_data_d = OMAX[WW_OUTPUT-1:0];
      o_sat_d  = 1'b1;
    end else if (shifted < OMIN) begin
      o_data_d = OMIN[WW_OUTPUT-1:0];
      o_sat_d  = 1'b1;
    end
  end

  // Output data/flag hold between valid results.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sat_q   <= 1'b0;
    end else begin
      o_valid_q <= vld_q[LVL];
      if (vld_q[LVL]) begin
        o_data_q <= o_data_d;
        o_sat_q  <= o_sat_d;
      end
    end
  end

  assign strm.o_valid = o_valid_q;
  assign strm.o_data  = o_data_q;
  assign strm.o_sat   = o_sat_q;
endmodule

// File: tb/tb_fir_stream_param.sv
// Bench for fir_stream_param: reference model built from the arithmetic
// definition of the filter (history array, coefficient array, latency queue),
// steady-state vector table, directed multi-cycle sequences, random traffic.
module tb_fir_stream_param;
  localparam int N   = 15;
  localparam int WI  = 8;
  localparam int WC  = 8;
  localparam int WO  = 8;
  localparam int SH  = 7;
  localparam int AW  = $clog2(N);
  localparam int LAT = 2 + $clog2(N);
  localparam longint OMAXV = (64'sd1 <<< (WO-1)) - 1;
  localparam longint OMINV = -(64'sd1 <<< (WO-1));

  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  fir_stream_param_if #(.N_TAPS(N), .WW_INPUT(WI), .WW_COEFF(WC), .WW_OUTPUT(WO)) bus ();

  fir_stream_param #(.N_TAPS(N), .WW_INPUT(WI), .WW_COEFF(WC), .WW_OUTPUT(WO), .SHIFT(SH)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .strm  (bus)
  );

  // Reference model state
  int     cm   [N];
  int     hist [N];       // hist[k] = sample k valid-steps ago (k >= 1)
  bit     pv   [LAT];
  longint pd   [LAT];
  bit     ps   [LAT];
  longint hold_d;
  bit     hold_s;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int n8     = 0;
  int first_v = -1;

  typedef struct {
    int c_all;
    int c0;
    int din;
    int exp_d;
    bit exp_s;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin cm[i] = 0; hist[i] = 0; end
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = 0; ps[i] = 0; end
    hold_d = 0;
    hold_s = 0;
  endtask

  // One clock cycle: drive inputs, advance model, check outputs after the edge.
  task automatic step(input bit v, input int d, input bit we = 1'b0,
                      input int a = 0, input int cd = 0);
    longint sum, s, rd;
    bit     rs;
    bus.i_valid      = v;
    bus.i_data       = d[WI-1:0];
    bus.i_coeff_we   = we;
    bus.i_coeff_addr = a[AW-1:0];
    bus.i_coeff_data = cd[WC-1:0];
    rd = 0;
    rs = 0;
    if (v) begin
      sum = longint'(d) * cm[0];
      for (int k = 1; k < N; k++) sum += longint'(hist[k]) * cm[k];
      s = sum >>> SH;
      if (s > OMAXV)      begin rd = OMAXV; rs = 1; end
      else if (s < OMINV) begin rd = OMINV; rs = 1; end
      else                rd = s;
      for (int k = N-1; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = d;
    end
    if (we && a < N) cm[a] = cd;
    for (int i = LAT-1; i >= 1; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; ps[i] = ps[i-1]; end
    pv[0] = v; pd[0] = rd; ps[0] = rs;
    @(posedge clk);
    #1;
    cyc++;
    if (pv[LAT-1]) begin hold_d = pd[LAT-1]; hold_s = ps[LAT-1]; end
    chk("o_valid", longint'(bus.o_valid), longint'(pv[LAT-1]));
    chk("o_data", longint'(bus.o_data), hold_d);
    chk("o_sat", longint'(bus.o_sat), longint'(hold_s));
    if (bus.o_valid && bus.o_data == 8) n8++;
    if (bus.o_valid && first_v < 0) first_v = cyc;
  endtask

  task automatic set_all(input int c);
    for (int k = 0; k < N; k++) step(1'b0, 0, 1'b1, k, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  initial begin
    int start;
    bit pat[7];
    bit obs[13];

    vecs[0]  = '{127, 127,  127,  127, 1'b1};
    vecs[1]  = '{127, 127, -128, -128, 1'b1};
    vecs[2]  = '{  0,   1,   -1,   -1, 1'b0};
    vecs[3]  = '{  0,   1,  100,    0, 1'b0};
    vecs[4]  = '{ 16,  16,   64,  120, 1'b0};
    vecs[5]  = '{  1,   1, -128,  -15, 1'b0};
    vecs[6]  = '{  1,   0,   -7,   -1, 1'b0};
    vecs[7]  = '{  4,   4,   17,    7, 1'b0};
    vecs[8]  = '{ 16,  16,   68,  127, 1'b0};
    vecs[9]  = '{ 16,  16,   69,  127, 1'b1};
    vecs[10] = '{ 16,  16,  -68, -128, 1'b0};
    vecs[11] = '{ 16,  16,  -69, -128, 1'b1};

    i_rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_coeff_we = 1'b0;
    bus.i_coeff_addr = '0; bus.i_coeff_data = '0;
    model_reset();
    #12;
    chk("reset_o_valid", longint'(bus.o_valid), 0);
    chk("reset_o_data", longint'(bus.o_data), 0);
    chk("reset_o_sat", longint'(bus.o_sat), 0);
    i_rst = 1'b0;

    // Impulse response
    set_all(16);
    n8 = 0; first_v = -1;
    step(1'b1, 64);
    start = cyc;
    for (int i = 0; i < 20; i++) step(1'b1, 0);
    chk("impulse_latency", longint'(first_v - start), longint'(LAT-1));
    chk("impulse_eights", longint'(n8), 15);
    idle(LAT);

    // Steady-state table
    for (int v = 0; v < 12; v++) begin
      set_all(vecs[v].c_all);
      step(1'b0, 0, 1'b1, 0, vecs[v].c0);
      for (int i = 0; i < N; i++) step(1'b1, vecs[v].din);
      idle(LAT-1);
      chk($sformatf("vec%0d_data", v), longint'(bus.o_data), longint'(vecs[v].exp_d));
      chk($sformatf("vec%0d_sat", v), longint'(bus.o_sat), longint'(vecs[v].exp_s));
    end

    // Valid gaps
    set_all(16);
    idle(N);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      if (i < 7) step(pat[i], (i == 0) ? 64 : 0);
      else       step(1'b0, 0);
      obs[i] = bus.o_valid;
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("gap_valid%0d", i), longint'(obs[i+LAT-1]), longint'(pat[i]));

    // Runtime coefficient change
    set_all(16);
    for (int i = 0; i < 20; i++) step(1'b1, 8);
    step(1'b1, 8, 1'b1, 0, 32);
    step(1'b1, 8);
    step(1'b1, 8, 1'b1, 15, 99);
    step(1'b1, 8);
    idle(2);
    chk("coef_same_cycle_old", longint'(bus.o_data), 15);
    idle(1);
    chk("coef_next_new", longint'(bus.o_data), 16);
    idle(2);
    chk("coef_addr15_ignored", longint'(bus.o_data), 16);
    idle(2);

    // Async reset with samples in flight
    set_all(20);
    for (int i = 0; i < 10; i++) step(1'b1, 50);
    #2;
    i_rst = 1'b1;
    #1;
    chk("midrst_o_valid", longint'(bus.o_valid), 0);
    chk("midrst_o_data", longint'(bus.o_data), 0);
    chk("midrst_o_sat", longint'(bus.o_sat), 0);
    model_reset();
    #1;
    i_rst = 1'b0;
    idle(10);
    set_all(16);
    step(1'b1, 64);
    idle(LAT-1);
    chk("post_reset_first", longint'(bus.o_data), 8);
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit v, we;
      int d, a, cd;
      v  = ($urandom_range(0, 3) != 0);
      d  = int'($urandom_range(0, 255)) - 128;
      we = ($urandom_range(0, 7) == 0);
      a  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) cd = int'($urandom_range(0, 255)) - 128;
      else                           cd = int'($urandom_range(0, 31)) - 16;
      step(v, d, we, a, cd);
    end
    idle(LAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_stream_param.md
Name: fir_stream_param

Overview:
- Parametrised successor to the lab02 fixed 15-tap FIR.
- Direct-form FIR with:
  - generic tap count and widths,
  - runtime-loadable coefficient bank (replaces the include-file coefficients),
  - valid-tagged streaming instead of a bare enable,
  - fully pipelined adder tree,
  - built-in shift/saturate output stage with an overflow flag.
- Sits between the sample source (ADC/PRBS path) and downstream decimation/BER logic.

Parameters:
- N_TAPS, 15, number of taps (2..64).
- WW_INPUT, 8, signed input sample width.
- WW_COEFF, 8, signed coefficient width.
- WW_OUTPUT, 8, signed output width.
- SHIFT, 7, arithmetic right shift applied to the full-precision sum before saturation.

Ports:
- clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  i_data holds a new sample this cycle.
- i_data  in  WW_INPUT  signed input sample.
- i_coeff_we  in  1  coefficient write strobe.
- i_coeff_addr  in  ceil(log2(N_TAPS))  tap index to write.
- i_coeff_data  in  WW_COEFF  signed coefficient value.
- o_valid  out  1  o_data holds a new result this cycle.
- o_data  out  WW_OUTPUT  signed filtered sample.
- o_sat  out  1  result on o_data was saturated; qualified by o_valid.

Behaviour:
- Reset (async, i_rst=1): delay line, coefficient bank, all pipeline registers and valid tags clear to 0. o_valid=0, o_data=0, o_sat=0. Asserting i_rst mid-stream discards in-flight samples. No o_valid may be produced from pre-reset data.
- Delay line:
  - x[0]=i_data (combinational), x[k]=register k, k=1..N_TAPS-1.
  - Shifts only when i_valid=1; holds otherwise.
- Products: p[k]=coeff[k]*x[k], full width WW_INPUT+WW_COEFF, signed. Registered on the cycle i_valid=1 (stage 1).
- Adder tree:
  - Pairwise sums, each level one bit wider, registered at every level.
  - ceil(log2(N_TAPS)) levels. An odd leftover operand is sign-extended and passed through that level's register.
  - Final width WA = WW_INPUT+WW_COEFF+ceil(log2(N_TAPS)). The tree never overflows.
- Output stage (registered):
  - s = sum >>> SHIFT (arithmetic, truncation toward minus infinity).
  - If s > 2^(WW_OUTPUT-1)-1: o_data=max, o_sat=1.
  - If s < -2^(WW_OUTPUT-1): o_data=min, o_sat=1.
  - Otherwise o_data=s[WW_OUTPUT-1:0], o_sat=0.
- Latency:
  - LAT = 2 + ceil(log2(N_TAPS)) clock edges from the i_valid sampling edge to o_valid high (N_TAPS=15 gives 6).
  - Valid tag travels with the data through every stage.
  - Throughput: one sample per cycle.
  - Gaps in i_valid produce identical gaps in o_valid.
- Hold: when o_valid=0, o_data and o_sat hold their last values.
- Coefficient writes:
  - On i_coeff_we=1, coeff[i_coeff_addr] <= i_coeff_data at the edge.
  - The new value applies to products registered at the next edge onward. Samples already past stage 1 are unaffected.
  - A write and i_valid in the same cycle: the sample uses the OLD coefficient.
  - Addresses >= N_TAPS are ignored; the bank is unchanged.
- Boundaries:
  - The first N_TAPS-1 outputs after reset use zero-filled history.
  - No internal wrap: the delay line is a pure shift register.

Test Plan:
- Impulse response: reset; coeff[k]=16 for all k; one sample 64 followed by 20 zeros, continuous i_valid -> first o_valid 6 cycles after the impulse. o_data=8 for exactly 15 consecutive outputs, then 0; o_sat=0 throughout.
- Positive saturation: all coeff=127, constant input 127 -> steady sum 241935, >>>7 = 1890 -> o_data=127, o_sat=1 from the 15th output on.
- Negative saturation and truncation:
  - all coeff=127, input -128 -> o_data=-128, o_sat=1.
  - coeff[0]=1, others 0: input -1 -> o_data=-1; input 100 -> o_data=0.
- Valid gaps: i_valid pattern 1,0,0,1,1,0,1 with an impulse -> o_valid reproduces the pattern delayed 6 cycles. o_data holds during gaps. Results match the gapless reference.
- Runtime coefficient change: mid-stream, write coeff[0]=32 in the same cycle as a valid sample -> that sample uses the old coeff[0]; the following sample uses 32. A write to address 15 leaves the bank unchanged.
- Async reset mid-stream: assert i_rst between clock edges while 5 samples are in flight -> o_valid, o_data and o_sat go to 0 immediately. After release, no stale o_valid appears and the first output reflects zero history.
